// File: rtl/usb_cmd_bridge.sv
// Bridges 16-bit USB command frames from the EP2 FIFO engine into 32-bit memory-bus
// transactions and streams the 16-bit response words back towards the EP6 path.
module usb_cmd_bridge #(
   parameter logic [7:0]  SYNC     = 8'hA5,
   parameter logic [7:0]  RSP_SYNC = 8'h5A,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        fpga_gclk,
   input  logic        reset,
   input  logic [15:0] rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [7:0]  err_cnt
);

   localparam logic [3:0]  OpWrite = 4'd1;
   localparam logic [3:0]  OpRead  = 4'd2;
   localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      StHdr, StAddrH, StAddrL, StDataH, StDataL, StBus, StRsp0, StRsp1, StRsp2
   } state_e;

   state_e      state_q;
   logic        rx_ready_q, tx_valid_q, mem_valid_q;
   logic [15:0] tx_data_q, tmo_cnt_q;
   logic [31:0] mem_addr_q, mem_wdata_q, rdata_q;
   logic [3:0]  mem_wstrb_q, strb_q;
   logic [7:0]  err_cnt_q;
   logic        is_read_q, rsp_more_q;

   logic rx_acc, tx_acc;
   assign rx_acc = rx_valid & rx_ready_q;
   assign tx_acc = tx_valid_q & tx_ready;

   always_ff @(posedge fpga_gclk) begin
      if (reset) begin
         state_q     <= StHdr;
         rx_ready_q  <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         err_cnt_q   <= '0;
         rdata_q     <= '0;
         strb_q      <= '0;
         tmo_cnt_q   <= '0;
         is_read_q   <= 1'b0;
         rsp_more_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StHdr: begin
               rx_ready_q <= 1'b1;
               if (rx_acc) begin
                  if (rx_data[15:8] != SYNC) begin
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  end else if (rx_data[7:4] != OpWrite && rx_data[7:4] != OpRead) begin
                     rx_ready_q <= 1'b0;
                     tx_valid_q <= 1'b1;
                     tx_data_q  <= {RSP_SYNC, 8'hEE};
                     rsp_more_q <= 1'b0;
                     state_q    <= StRsp0;
                  end else begin
                     is_read_q <= (rx_data[7:4] == OpRead);
                     strb_q    <= rx_data[3:0];
                     state_q   <= StAddrH;
                  end
               end
            end
            StAddrH: if (rx_acc) begin
               mem_addr_q[31:16] <= rx_data;
               state_q           <= StAddrL;
            end
            StAddrL: if (rx_acc) begin
               mem_addr_q[15:0] <= rx_data;
               if (is_read_q) begin
                  rx_ready_q  <= 1'b0;
                  mem_valid_q <= 1'b1;
                  mem_wstrb_q <= 4'b0000;
                  tmo_cnt_q   <= '0;
                  state_q     <= StBus;
               end else begin
                  state_q <= StDataH;
               end
            end
            StDataH: if (rx_acc) begin
               mem_wdata_q[31:16] <= rx_data;
               state_q            <= StDataL;
            end
            StDataL: if (rx_acc) begin
               mem_wdata_q[15:0] <= rx_data;
               rx_ready_q        <= 1'b0;
               mem_valid_q       <= 1'b1;
               mem_wstrb_q       <= strb_q;
               tmo_cnt_q         <= '0;
               state_q           <= StBus;
            end
            StBus: begin
               // A ready on the last allowed cycle still counts as a completed access.
               if (mem_ready) begin
                  mem_valid_q <= 1'b0;
                  rdata_q     <= mem_rdata;
                  tx_valid_q  <= 1'b1;
                  tx_data_q   <= {RSP_SYNC, is_read_q ? 8'h02 : 8'h01};
                  rsp_more_q  <= is_read_q;
                  state_q     <= StRsp0;
               end else if (tmo_cnt_q == TmoLast) begin
                  mem_valid_q <= 1'b0;
                  tx_valid_q  <= 1'b1;
                  tx_data_q   <= {RSP_SYNC, 8'hEF};
                  rsp_more_q  <= 1'b0;
                  state_q     <= StRsp0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
            end
            StRsp0: if (tx_acc) begin
               if (rsp_more_q) begin
                  tx_data_q <= rdata_q[31:16];
                  state_q   <= StRsp1;
               end else begin
                  tx_valid_q <= 1'b0;
                  rx_ready_q <= 1'b1;
                  state_q    <= StHdr;
               end
            end
            StRsp1: if (tx_acc) begin
               tx_data_q <= rdata_q[15:0];
               state_q   <= StRsp2;
            end
            StRsp2: if (tx_acc) begin
               tx_valid_q <= 1'b0;
               rx_ready_q <= 1'b1;
               state_q    <= StHdr;
            end
            default: state_q <= StHdr;
         endcase
      end
   end

   assign rx_ready  = rx_ready_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_usb_cmd_bridge.sv
// Randomized frame-level bench for usb_cmd_bridge: a frame model predicts bus accesses,
// response words and the sync-error count, with random FIFO gaps and EP6 back-pressure.
module tb_usb_cmd_bridge;

   localparam int unsigned Tmo = 8;

   logic        fpga_gclk;
   logic        reset;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [7:0]  err_cnt;

   usb_cmd_bridge #(.TIMEOUT(Tmo)) dut (
      .fpga_gclk (fpga_gclk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .err_cnt   (err_cnt)
   );

   initial fpga_gclk = 1'b0;
   always #5 fpga_gclk = ~fpga_gclk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Environment state shared between the main thread and the responders.
   logic [15:0] tx_log[$];
   logic [31:0] bus_addr[$], bus_wdata[$];
   logic [3:0]  bus_strb[$];
   int          bus_len[$];
   int          mem_lat = 0;
   bit          mem_hang = 0;
   logic [31:0] mem_rd = '0;
   int          tx_budget = -1;
   int          err_model = 0;

   // Memory slave: logs each request, answers after mem_lat cycles unless hung.
   initial begin : mem_resp
      int vcnt;
      vcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge fpga_gclk);
         if (mem_valid) begin
            vcnt++;
            if (vcnt == 1) begin
               bus_addr.push_back(mem_addr);
               bus_wdata.push_back(mem_wdata);
               bus_strb.push_back(mem_wstrb);
            end
            mem_ready = !mem_hang && (vcnt > mem_lat);
            mem_rdata = mem_ready ? mem_rd : $urandom;
         end else begin
            if (vcnt > 0) bus_len.push_back(vcnt);
            vcnt = 0;
            mem_ready = 1'b0;
         end
      end
   end

   // EP6 sink: random or budgeted back-pressure, checks that stalled words hold.
   initial begin : tx_col
      bit          prev_hold;
      logic [15:0] prev_data;
      prev_hold = 0;
      prev_data = '0;
      tx_ready = 1'b0;
      forever begin
         @(negedge fpga_gclk);
         if (reset) begin
            prev_hold = 0;
         end else begin
            if (prev_hold)
               check_eq("tx_hold", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, prev_data});
            if (tx_budget >= 0) tx_ready = (tx_budget > 0);
            else tx_ready = ($urandom_range(0, 3) != 0);
            if (tx_valid && tx_ready) begin
               tx_log.push_back(tx_data);
               if (tx_budget > 0) tx_budget--;
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
         end
      end
   end

   task automatic send_word(input logic [15:0] w);
      int gap = $urandom_range(0, 2);
      bit ok = 0;
      repeat (gap) @(negedge fpga_gclk);
      @(negedge fpga_gclk);
      rx_valid = 1'b1;
      rx_data  = w;
      for (int i = 0; i < 300; i++) begin
         if (rx_ready) begin
            @(posedge fpga_gclk);
            ok = 1;
            break;
         end
         @(negedge fpga_gclk);
      end
      #1;
      rx_valid = 1'b0;
      rx_data  = 16'($urandom);
      if (!ok) check_eq("rx_accept", 32'd0, 32'd1);
   endtask

   // Sends one frame (or a lone bad word) and checks it against the frame model.
   task automatic do_frame(input logic [15:0] hdr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int lat, input bit hang);
      logic [15:0] words[5];
      logic [15:0] exp_tx[$];
      int          nwords = 1;
      bit          is_bus = 0;
      bit          is_wr = 0;
      logic [3:0]  exp_strb = '0;
      int          exp_len = 0;
      tx_log.delete();
      bus_addr.delete();
      bus_wdata.delete();
      bus_strb.delete();
      bus_len.delete();
      mem_lat  = lat;
      mem_hang = hang;
      mem_rd   = rdata;
      words = '{hdr, addr[31:16], addr[15:0], wdata[31:16], wdata[15:0]};
      if (hdr[15:8] != 8'hA5) begin
         if (err_model < 255) err_model++;
      end else if (hdr[7:4] == 4'd1 || hdr[7:4] == 4'd2) begin
         is_bus   = 1;
         is_wr    = (hdr[7:4] == 4'd1);
         nwords   = is_wr ? 5 : 3;
         exp_strb = is_wr ? hdr[3:0] : 4'b0000;
         exp_len  = hang ? int'(Tmo) : lat + 1;
         if (hang) exp_tx.push_back(16'h5AEF);
         else if (is_wr) exp_tx.push_back(16'h5A01);
         else begin
            exp_tx.push_back(16'h5A02);
            exp_tx.push_back(rdata[31:16]);
            exp_tx.push_back(rdata[15:0]);
         end
      end else begin
         exp_tx.push_back(16'h5AEE);
      end
      for (int i = 0; i < nwords; i++) send_word(words[i]);
      for (int c = 0; c < 400 && tx_log.size() < exp_tx.size(); c++) @(negedge fpga_gclk);
      repeat (3) @(negedge fpga_gclk);
      check_eq("tx_count", tx_log.size(), exp_tx.size());
      foreach (exp_tx[i]) if (i < tx_log.size()) check_eq("tx_word", {16'h0, tx_log[i]},
                                                          {16'h0, exp_tx[i]});
      check_eq("bus_count", bus_addr.size(), 32'(is_bus));
      if (is_bus && bus_addr.size() > 0) begin
         check_eq("mem_addr", bus_addr[0], addr);
         if (is_wr) check_eq("mem_wdata", bus_wdata[0], wdata);
         check_eq("mem_wstrb", {28'h0, bus_strb[0]}, {28'h0, exp_strb});
         check_eq("valid_len", bus_len.size() > 0 ? bus_len[0] : 0, exp_len);
      end
      check_eq("err_cnt", {24'h0, err_cnt}, err_model);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      logic [15:0] hdr;
      logic [3:0]  op;
      int          kind;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = '0;
      repeat (3) @(posedge fpga_gclk);
      @(negedge fpga_gclk);
      check_eq("rst_rx_ready", {31'h0, rx_ready}, 0);
      check_eq("rst_tx_valid", {31'h0, tx_valid}, 0);
      check_eq("rst_tx_data", {16'h0, tx_data}, 0);
      check_eq("rst_mem_valid", {31'h0, mem_valid}, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_mem_wstrb", {28'h0, mem_wstrb}, 0);
      check_eq("rst_err_cnt", {24'h0, err_cnt}, 0);
      reset = 1'b0;

      do_frame(16'hA514, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 0);
      do_frame(16'hA520, 32'h0000_0040, 32'h0, 32'h1234_5678, 3, 0);
      do_frame(16'h0000, 32'h0, 32'h0, 32'h0, 0, 0);
      do_frame(16'hFF20, 32'h0, 32'h0, 32'h0, 0, 0);
      do_frame(16'hA520, 32'h8000_0004, 32'h0, 32'hA5A5_0F0F, 1, 0);
      do_frame(16'hA570, 32'h0, 32'h0, 32'h0, 0, 0);
      do_frame(16'hA52F, 32'h0000_0100, 32'h0, 32'h0, 0, 1);
      do_frame(16'hA510, 32'h0000_2000, 32'h1111_2222, 32'h0, 0, 0);
      do_frame(16'hA51F, 32'hFFFF_FFFC, 32'h3333_4444, 32'h0, 7, 0);
      do_frame(16'hA51F, 32'h0000_0200, 32'h5555_6666, 32'h0, 0, 1);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         op   = (kind < 4) ? 4'd1 : (kind < 8) ? 4'd2 : 4'd0;
         if (kind == 8) op = 4'($urandom_range(3, 15));
         hdr  = {8'hA5, op, 4'($urandom)};
         if (kind == 9) begin
            hdr = 16'($urandom);
            if (hdr[15:8] == 8'hA5) hdr[15] = 1'b0;
         end
         do_frame(hdr, $urandom, $urandom, $urandom, $urandom_range(0, 6),
                  ($urandom_range(0, 7) == 0));
      end

      for (int n = 0; n < 260; n++) do_frame(16'h1234, 32'h0, 32'h0, 32'h0, 0, 0);
      check_eq("err_sat", {24'h0, err_cnt}, 32'hFF);

      // Stall in the second response word, then reset out of it.
      tx_log.delete();
      tx_budget = 1;
      mem_lat   = 1;
      mem_hang  = 0;
      mem_rd    = 32'hCAFE_F00D;
      send_word(16'hA520);
      send_word(16'h0000);
      send_word(16'h0080);
      for (int c = 0; c < 200 && tx_log.size() < 1; c++) @(negedge fpga_gclk);
      repeat (20) @(negedge fpga_gclk);
      check_eq("stall_first", tx_log.size() > 0 ? {16'h0, tx_log[0]} : 32'hFFFF_FFFF,
               32'h5A02);
      check_eq("stall_valid", {31'h0, tx_valid}, 1);
      check_eq("stall_data", {16'h0, tx_data}, 32'hCAFE);
      reset = 1'b1;
      repeat (2) @(posedge fpga_gclk);
      @(negedge fpga_gclk);
      check_eq("rst2_tx_valid", {31'h0, tx_valid}, 0);
      check_eq("rst2_rx_ready", {31'h0, rx_ready}, 0);
      check_eq("rst2_err_cnt", {24'h0, err_cnt}, 0);
      check_eq("rst2_mem_valid", {31'h0, mem_valid}, 0);
      reset     = 1'b0;
      err_model = 0;
      tx_budget = -1;
      do_frame(16'hA520, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 2, 0);
      do_frame(16'hA513, 32'h0000_0014, 32'h7777_8888, 32'h0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
